// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: drives a 4-bit ALU one nibble per cycle, LSB first,
// chaining carry through a register and assembling a W = 4*NIBBLES result.
// Optional feature macro: ALU_SEQ_OVF_EN adds a signed-overflow flag (ovf).
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a_in,
    input  logic [4*NIBBLES-1:0]   b_in,
    input  logic [3:0]             s_in,
    input  logic                   m_in,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   zero,
`ifdef ALU_SEQ_OVF_EN
    output logic                   ovf,
`endif
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_s,
    output logic                   alu_m,
    output logic                   alu_pin,
    input  logic [3:0]             alu_r,
    input  logic                   alu_pout
);

    localparam int W  = 4 * NIBBLES;
    // keep the index at least one bit wide so NIBBLES = 1 still elaborates
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, b_q;
    logic [3:0]      s_q;
    logic            m_q;
    logic            carry_q;
    logic [IW-1:0]   idx_q;
    logic [W-1:0]    next_result;
    logic            accept;
    logic            last;

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));
    assign last   = (idx_q == IW'(NIBBLES - 1));

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next-state logic and status outputs
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ALU operand nibble select; nibble 0 outside RUN so the ALU never sees X
    always_comb begin
        alu_a = a_q[3:0];
        alu_b = b_q[3:0];
        if (state_q == RUN) begin
            for (int n = 0; n < NIBBLES; n++) begin
                if (idx_q == IW'(n)) begin
                    alu_a = a_q[4*n +: 4];
                    alu_b = b_q[4*n +: 4];
                end
            end
        end
    end

    assign alu_s   = s_q;
    assign alu_m   = m_q;
    assign alu_pin = carry_q;

    // result word with the current ALU nibble merged in at idx
    always_comb begin
        next_result = result;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IW'(n)) next_result[4*n +: 4] = alu_r;
        end
    end

    // operand latch, carry chain, result assembly and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            result  <= '0;
            cout    <= 1'b0;
            zero    <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= a_in;
            b_q     <= b_in;
            s_q     <= s_in;
            m_q     <= m_in;
            carry_q <= cin;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            result  <= next_result;
            carry_q <= alu_pout;
            if (last) begin
                // flags land with the final nibble so they are valid in DONE
                idx_q <= '0;
                cout  <= alu_pout;
                zero  <= (next_result == '0);
`ifdef ALU_SEQ_OVF_EN
                ovf   <= !m_q && (a_q[W-1] == b_q[W-1]) &&
                         (next_result[W-1] != a_q[W-1]);
`endif
            end else begin
                idx_q <= idx_q + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer (NIBBLES = 4) with a 4-bit adder ALU model.
// Expected values come from whole-word arithmetic: {cout,result} = a + b + cin.
module tb_alu_nibble_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a_in = '0, b_in = '0;
    logic [3:0]  s_in = '0;
    logic        m_in = 1'b0, cin = 1'b0;
    logic        busy, done, cout, zero;
    logic [15:0] result;
    logic [3:0]  alu_a, alu_b, alu_s, alu_r;
    logic        alu_m, alu_pin, alu_pout;
`ifdef ALU_SEQ_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    alu_nibble_sequencer #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_in(a_in), .b_in(b_in), .s_in(s_in), .m_in(m_in), .cin(cin),
        .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
`ifdef ALU_SEQ_OVF_EN
        .ovf(ovf),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m),
        .alu_pin(alu_pin), .alu_r(alu_r), .alu_pout(alu_pout)
    );

    // 4-bit adder standing in for the ParallelALU
    assign {alu_pout, alu_r} = 5'(alu_a) + 5'(alu_b) + 5'(alu_pin);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic m, input logic [3:0] s);
        a_in = a; b_in = b; cin = c; m_in = m; s_in = s; start = 1'b1;
    endtask

    // accept the launched op, walk RUN, check the DONE cycle; returns in DONE
    task automatic finish_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                             input logic m, input logic [3:0] s, input bit inject);
        logic [16:0] sum;
        logic [15:0] r;
        sum = 17'(a) + 17'(b) + 17'(c);
        r   = sum[15:0];
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("run_busy", 32'(busy), 32'd1);
            check("run_done", 32'(done), 32'd0);
            check("run_alu_a", 32'(alu_a), 32'((a >> (4*i)) & 16'hF));
            check("run_alu_b", 32'(alu_b), 32'((b >> (4*i)) & 16'hF));
            check("run_alu_s", 32'(alu_s), 32'(s));
            check("run_alu_m", 32'(alu_m), 32'(m));
            if (inject && i == 1) begin
                start = 1'b1;
                a_in  = ~a;
                b_in  = ~b;
            end
            step();
            start = 1'b0;
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("result", 32'(result), 32'(r));
        check("cout", 32'(cout), 32'(sum[16]));
        check("zero", 32'(zero), 32'(r == 16'h0));
`ifdef ALU_SEQ_OVF_EN
        check("ovf", 32'(ovf), 32'(!m && (a[15] == b[15]) && (r[15] != a[15])));
`endif
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rc, rm;
        logic [3:0]  rs;

        // 1. reset
        step(); step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_result", 32'(result), 32'h0);
        check("rst_alu_a", 32'(alu_a), 32'h0);
`ifdef ALU_SEQ_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        // 2. basic add
        launch(16'h1234, 16'h4321, 1'b0, 1'b0, 4'h9);
        finish_op(16'h1234, 16'h4321, 1'b0, 1'b0, 4'h9, 1'b0);
        step();
        check("done_one_cycle", 32'(done), 32'd0);
        check("result_held", 32'(result), 32'h5555);
        check("idle_alu_a_nib0", 32'(alu_a), 32'h4);

        // 3. full ripple to zero
        launch(16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'h9);
        finish_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'h9, 1'b0);
        step();

        // 4. signed overflow case
        launch(16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'h9);
        finish_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'h9, 1'b0);
        step();

        // 5. start during RUN ignored; start in DONE runs back-to-back
        launch(16'h0F0F, 16'h1111, 1'b1, 1'b0, 4'h3);
        finish_op(16'h0F0F, 16'h1111, 1'b1, 1'b0, 4'h3, 1'b1);
        launch(16'hABCD, 16'h1357, 1'b0, 1'b1, 4'hC);
        finish_op(16'hABCD, 16'h1357, 1'b0, 1'b1, 4'hC, 1'b0);
        step();
        check("b2b_done_clear", 32'(done), 32'd0);
        check("b2b_idle_busy", 32'(busy), 32'd0);

        // 6. reset in the 3rd RUN cycle aborts without done
        launch(16'h8888, 16'h8888, 1'b1, 1'b0, 4'h5);
        step();
        start = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'h0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_zero", 32'(zero), 32'd0);
        check("abort_alu_s", 32'(alu_s), 32'h0);
        check("abort_alu_pin", 32'(alu_pin), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("abort_no_done", 32'(done), 32'd0);
        end

        // random operations, every third one launched back-to-back from DONE
        for (int k = 0; k < 24; k++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rm = 1'($urandom); rs = 4'($urandom);
            launch(ra, rb, rc, rm, rs);
            finish_op(ra, rb, rc, rm, rs, (k % 4) == 1);
            if ((k % 3) != 2) step();
        end
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
